// File: rtl/arb_pkg.sv
// Shared types, default sizing and slice-length clamp for the round-robin slot arbiter.
package arb_pkg;

  localparam int N_REQ_DEF     = 6;
  localparam int ID_W_DEF      = 3;
  localparam int MAX_SLICE_DEF = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // A zero slice still buys one cycle; anything above the ceiling is clipped.
  function automatic int eff_len(input int len, input int max_slice);
    if (len == 0) return 1;
    if (len > max_slice) return max_slice;
    return len;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 6,
  parameter int ID_W  = 3
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  winner,
  output logic [N_REQ-1:0] onehot
);

  int idx;

  // Walk from the farthest offset down so the nearest hit is the last one written.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
        onehot = '0;
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_slot_arbiter.sv
// Time-slice round-robin arbiter: registered one-hot grant, 1-cycle grant latency, 1 dead cycle per handover.
// Optional ARB_LOCK_EN adds a lock input that suppresses slice-expiry preemption.
module rr_slot_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int ID_W      = ID_W_DEF,
  parameter int MAX_SLICE = MAX_SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  slice_len,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic [ID_W-1:0]  gnt_id,
  output logic [ID_W-1:0]  slot_cnt,
  output logic             expire
);

  state_t          state;
  logic [ID_W-1:0] ptr;

  logic             found;
  logic [ID_W-1:0]  win_id;
  logic [N_REQ-1:0] win_oh;
  logic [ID_W-1:0]  ptr_next;

  int   len_eff;
  logic at_end;
  logic others;
  logic held;
  logic no_preempt;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .found  (found),
    .winner (win_id),
    .onehot (win_oh)
  );

`ifdef ARB_LOCK_EN
  assign no_preempt = lock;
`else
  assign no_preempt = 1'b0;
`endif

  // ">=" rather than "==" so a slice shortened mid-grant expires on the next enabled cycle.
  always_comb begin
    len_eff  = eff_len(int'(slice_len), MAX_SLICE);
    at_end   = int'(slot_cnt) >= (len_eff - 1);
    others   = |(req & ~gnt);
    held     = |(req & gnt);
    ptr_next = (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
  end

  assign gnt_valid = |gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      slot_cnt <= '0;
      expire   <= 1'b0;
      ptr      <= '0;
    end else begin
      expire <= 1'b0;
      case (state)
        GRANT: begin
          // A dropped request releases even while frozen, and never counts as expiry.
          if (!held) begin
            state    <= RELEASE;
            gnt      <= '0;
            gnt_id   <= '0;
            slot_cnt <= '0;
          end else if (en) begin
            if (at_end) begin
              if (others && !no_preempt) begin
                state    <= RELEASE;
                gnt      <= '0;
                gnt_id   <= '0;
                slot_cnt <= '0;
                expire   <= 1'b1;
              end else begin
                slot_cnt <= '0;
              end
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end
        end
        default: begin
          if (en && found) begin
            state    <= GRANT;
            gnt      <= win_oh;
            gnt_id   <= win_id;
            slot_cnt <= '0;
            ptr      <= ptr_next;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
